// File: rtl/sap_pkg.sv
// Shared types and constants for the SAP operand/accumulator stage.
package sap_pkg;

  localparam int SAP_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_LDA = 2'd0,
    OP_LDB = 2'd1,
    OP_ADD = 2'd2,
    OP_SUB = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

  // Two's-complement overflow: ADD needs equal operand signs, SUB needs opposite ones.
  function automatic logic calc_ovf(input logic                 is_sub,
                                    input logic [SAP_WIDTH-1:0] a,
                                    input logic [SAP_WIDTH-1:0] b,
                                    input logic [SAP_WIDTH-1:0] r);
    logic signs_match;
    signs_match = (a[SAP_WIDTH-1] == b[SAP_WIDTH-1]);
    return (is_sub ? !signs_match : signs_match) && (r[SAP_WIDTH-1] != a[SAP_WIDTH-1]);
  endfunction

endpackage

// File: rtl/sap_reg8.sv
// 8-bit register with synchronous load enable and asynchronous active-low clear.
module sap_reg8
  import sap_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [SAP_WIDTH-1:0] d,
  output logic [SAP_WIDTH-1:0] q
);

  logic [SAP_WIDTH-1:0] q_q;
  logic [SAP_WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/alu_operand_stage.sv
// Operand/accumulator stage feeding the 8-bit add/subtract ALU.
// Status flag register is present only when ALU_FLAGS_EN is defined.
module alu_operand_stage
  import sap_pkg::*;
#(
  parameter int WIDTH = SAP_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  output logic             op_ready,
  output logic             done,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             alu_enable,
  output logic             alu_subtract,
  input  logic [WIDTH-1:0] alu_result,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_ovf
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic             done_q, done_d;
  logic             accept;
  logic             a_load, b_load;
  logic [WIDTH-1:0] a_d;
  logic             in_exec;

  assign op_ready = (state_q == ST_IDLE);
  assign accept   = op_valid && op_ready;
  assign in_exec  = (state_q == ST_EXEC);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    done_d  = 1'b0;
    a_load  = 1'b0;
    b_load  = 1'b0;
    a_d     = bus_in;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op_e'(op_code))
            OP_LDA: begin
              a_load = 1'b1;
              done_d = 1'b1;
            end
            OP_LDB: begin
              b_load = 1'b1;
              done_d = 1'b1;
            end
            default: begin
              state_d = ST_EXEC;
              op_d    = op_e'(op_code);
            end
          endcase
        end
      end
      ST_EXEC: begin
        // Writeback of the ALU result closes the arithmetic op.
        a_load  = 1'b1;
        a_d     = alu_result;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LDA;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  sap_reg8 u_reg_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (a_load),
    .d     (a_d),
    .q     (a_out)
  );

  sap_reg8 u_reg_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (b_load),
    .d     (bus_in),
    .q     (b_out)
  );

  assign done         = done_q;
  assign alu_enable   = in_exec;
  assign alu_subtract = in_exec && (op_q == OP_SUB);

`ifdef ALU_FLAGS_EN
  flags_t flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (in_exec) begin
      flags_d.zero = (alu_result == '0);
      flags_d.neg  = alu_result[WIDTH-1];
      flags_d.ovf  = calc_ovf(op_q == OP_SUB, a_out, b_out, alu_result);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flag_zero = flags_q.zero;
  assign flag_neg  = flags_q.neg;
  assign flag_ovf  = flags_q.ovf;
`else
  assign flag_zero = 1'b0;
  assign flag_neg  = 1'b0;
  assign flag_ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage with a behavioural 8-bit ALU attached.
module tb_alu_operand_stage;

`ifdef ALU_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] bus_in;
  logic       op_valid;
  logic [1:0] op_code;
  logic       op_ready;
  logic       done;
  logic [7:0] a_out;
  logic [7:0] b_out;
  logic       alu_enable;
  logic       alu_subtract;
  logic [7:0] alu_result;
  logic       flag_zero;
  logic       flag_neg;
  logic       flag_ovf;

  int n_checks = 0;
  int n_errors = 0;

  alu_operand_stage #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus_in       (bus_in),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .op_ready     (op_ready),
    .done         (done),
    .a_out        (a_out),
    .b_out        (b_out),
    .alu_enable   (alu_enable),
    .alu_subtract (alu_subtract),
    .alu_result   (alu_result),
    .flag_zero    (flag_zero),
    .flag_neg     (flag_neg),
    .flag_ovf     (flag_ovf)
  );

  // Downstream ALU: outputs 0 unless enabled, carry dropped.
  assign alu_result = alu_enable ? (alu_subtract ? a_out - b_out : a_out + b_out) : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic z, input logic n, input logic v);
    check({tag, ".zero"}, flag_zero, FLAGS_EN ? z : 1'b0);
    check({tag, ".neg"},  flag_neg,  FLAGS_EN ? n : 1'b0);
    check({tag, ".ovf"},  flag_ovf,  FLAGS_EN ? v : 1'b0);
  endtask

  // Issue one op from a negedge and follow it to its done pulse.
  task automatic run_op(input string tag, input logic [1:0] code, input logic [7:0] data);
    int lat;
    lat = (code >= 2'd2) ? 2 : 1;
    @(negedge clk);
    check({tag, ".ready"}, op_ready, 1'b1);
    op_valid = 1'b1;
    op_code  = code;
    bus_in   = data;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i < lat) begin
        check({tag, ".done_early"}, done, 1'b0);
        check({tag, ".alu_en"}, alu_enable, 1'b1);
        check({tag, ".alu_sub"}, alu_subtract, (code == 2'd3));
        check({tag, ".ready_exec"}, op_ready, 1'b0);
      end else begin
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".alu_en_off"}, alu_enable, 1'b0);
      end
    end
    $display("op %s code=%0d data=0x%02h -> A=0x%02h B=0x%02h Z=%0b N=%0b V=%0b",
             tag, code, data, a_out, b_out, flag_zero, flag_neg, flag_ovf);
  endtask

  task automatic arith(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic is_sub, input logic [7:0] exp_a,
                       input logic z, input logic n, input logic v);
    run_op({tag, ".lda"}, 2'd0, a);
    run_op({tag, ".ldb"}, 2'd1, b);
    run_op(tag, is_sub ? 2'd3 : 2'd2, 8'hxx);
    check({tag, ".A"}, a_out, exp_a);
    check({tag, ".B"}, b_out, b);
    check_flags(tag, z, n, v);
  endtask

  initial begin
    rst_n    = 1'b0;
    bus_in   = 8'h00;
    op_valid = 1'b0;
    op_code  = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.A", a_out, 8'h00);
    check("rst.B", b_out, 8'h00);
    check("rst.ready", op_ready, 1'b1);
    check("rst.done", done, 1'b0);
    check("rst.alu_en", alu_enable, 1'b0);
    check("rst.alu_sub", alu_subtract, 1'b0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);

    arith("add5p3",   8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
    arith("sub3m5",   8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b1, 1'b0);
    arith("sub5m5",   8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    arith("add7Fp1",  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    arith("sub80m1",  8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b0, 1'b1);

    // Loads must not disturb the flags left by the last SUB.
    run_op("lda_keep", 2'd0, 8'h00);
    check("lda_keep.A", a_out, 8'h00);
    check_flags("lda_keep", 1'b0, 1'b0, 1'b1);

    arith("addFFp2",  8'hFF, 8'h02, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);

    // LDB held on the bus during EXEC must wait for op_ready.
    run_op("hold.lda", 2'd0, 8'h10);
    run_op("hold.ldb", 2'd1, 8'h20);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 2'd2;
    @(posedge clk);
    #1;
    op_code = 2'd1;
    bus_in  = 8'h55;
    @(negedge clk);
    check("hold.exec_ready", op_ready, 1'b0);
    check("hold.exec_B", b_out, 8'h20);
    check("hold.exec_A", a_out, 8'h10);
    check("hold.exec_done", done, 1'b0);
    @(negedge clk);
    check("hold.add_done", done, 1'b1);
    check("hold.add_A", a_out, 8'h30);
    check("hold.B_pending", b_out, 8'h20);
    check("hold.ready_back", op_ready, 1'b1);
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    check("hold.ldb_B", b_out, 8'h55);
    check("hold.ldb_done", done, 1'b1);
    @(negedge clk);
    check("hold.done_drop", done, 1'b0);
    $display("op hold: A=0x%02h B=0x%02h", a_out, b_out);

    arith("add80p80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Abort an ADD with reset while in EXEC.
    run_op("abort.lda", 2'd0, 8'h11);
    run_op("abort.ldb", 2'd1, 8'h22);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = 2'd2;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    @(negedge clk);
    check("abort.pre_en", alu_enable, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort.A", a_out, 8'h00);
    check("abort.B", b_out, 8'h00);
    check("abort.ready", op_ready, 1'b1);
    check("abort.alu_en", alu_enable, 1'b0);
    check("abort.alu_sub", alu_subtract, 1'b0);
    check("abort.done", done, 1'b0);
    check_flags("abort", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort.post_done", done, 1'b0);
    check("abort.post_A", a_out, 8'h00);
    $display("op abort: A=0x%02h B=0x%02h done=%0b", a_out, b_out, done);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
